// File: rtl/jtag_master_pkg.sv
`default_nettype none
// =============================================================================
// Module   : jtag_master_pkg
// Brief    : Opcodes, FSM state codes and TMS preamble/postamble tables for
//            the JTAG scan master.
// Revision : 1.0 - initial release
// =============================================================================
package jtag_master_pkg;

    localparam logic [1:0] OP_RST  = 2'd0;
    localparam logic [1:0] OP_IR   = 2'd1;
    localparam logic [1:0] OP_DR   = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    localparam logic [1:0] ST_AUTO_RST = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_SEQ      = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [1:0] PH_PREAMBLE  = 2'd0;
    localparam logic [1:0] PH_SHIFT     = 2'd1;
    localparam logic [1:0] PH_POSTAMBLE = 2'd2;

    localparam int RST_TCKS   = 6;
    localparam int IR_PRE     = 4;
    localparam int DR_PRE     = 3;
    localparam int POST_EARLY = 2;
    localparam int POST_PAUSE = 4;

    // TMS patterns, bit 0 is driven on the first TCK of the segment
    localparam logic [7:0] RST_TMS        = 8'b0001_1111;
    localparam logic [7:0] IR_PRE_TMS     = 8'b0000_0011;
    localparam logic [7:0] DR_PRE_TMS     = 8'b0000_0001;
    localparam logic [7:0] POST_EARLY_TMS = 8'b0000_0001;
    localparam logic [7:0] POST_PAUSE_TMS = 8'b0000_0110;

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// =============================================================================
// Module   : jtag_tck_gen
// Brief    : TCK divider, TCK_DIV clk per half period, with rise/fall strobes
//            valid in the clk before tck changes. Held low while disabled.
// Revision : 1.0 - initial release
// =============================================================================
module jtag_tck_gen #(
    parameter int TCK_DIV = 5
) (
    input  logic clk,
    input  logic trst_,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tck_q;
    logic          w_term;

    assign w_term = (cnt_q == CW'(TCK_DIV - 1));
    assign rise_o = en_i & w_term & ~tck_q;
    assign fall_o = en_i & w_term & tck_q;
    assign tck_o  = tck_q;

    always_ff @(posedge clk or posedge trst_) begin
        if (trst_) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (w_term) begin
            cnt_q <= '0;
            tck_q <= ~tck_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// =============================================================================
// Module   : jtag_master
// Brief    : Converts reset/IR/DR scan commands into TCK/TMS/TDI sequences,
//            always leaving the TAP in Run-Test-Idle. TDO capture is present
//            only when JTAG_MASTER_TDO_CAPTURE_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int IR_LENGTH   = 4,
    parameter int MAX_DR_BITS = 64,
    parameter int TCK_DIV     = 5
) (
    input  logic                          clk,
    input  logic                          trst_,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [$clog2(MAX_DR_BITS):0]  cmd_bits,
    input  logic                          cmd_pause,
    input  logic [MAX_DR_BITS-1:0]        cmd_data,
    output logic                          rsp_valid,
    output logic [MAX_DR_BITS-1:0]        rsp_data,
    output logic                          busy,
    output logic                          tck,
    output logic                          tms,
    output logic                          tdi,
    input  logic                          tdo
);

    localparam int BW = $clog2(MAX_DR_BITS) + 1;
    localparam int IW = (MAX_DR_BITS > 1) ? $clog2(MAX_DR_BITS) : 1;
    localparam int PW = $clog2(MAX_DR_BITS + IR_LENGTH + 8) + 1;

    logic [1:0]             state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic                   pause_q, pause_d;
    logic [BW-1:0]          n_q, n_d;
    logic [MAX_DR_BITS-1:0] data_q, data_d;
    logic [PW-1:0]          pos_q, pos_d;
    logic                   upd_q, upd_d;
    logic                   tms_q, tms_d;
    logic                   tdi_q, tdi_d;
    logic                   rsp_valid_q, rsp_valid_d;

    logic          w_gen_en, w_rise, w_fall;
    logic [PW-1:0] w_pre_len, w_post_len, w_n, w_shift_end, w_total;
    logic [7:0]    w_pre_tms, w_post_tms;
    logic [1:0]    w_phase;
    logic [2:0]    w_post_pos;
    logic [IW-1:0] w_idx;
    logic          w_tms_next, w_tdi_next, w_last;

    // First TCK low phase is one clk longer: the TMS/TDI load slot after accept
    assign w_gen_en = (state_q != ST_IDLE) & ~(upd_q & (pos_q == '0));

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk    (clk),
        .trst_  (trst_),
        .en_i   (w_gen_en),
        .tck_o  (tck),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    always_comb begin
        w_pre_len  = PW'(RST_TCKS);
        w_pre_tms  = RST_TMS;
        w_post_len = '0;
        w_post_tms = '0;
        w_n        = '0;
        case (op_q)
            OP_IR: begin
                w_pre_len  = PW'(IR_PRE);
                w_pre_tms  = IR_PRE_TMS;
                w_n        = PW'(IR_LENGTH);
                w_post_len = PW'(POST_EARLY);
                w_post_tms = POST_EARLY_TMS;
            end
            OP_DR: begin
                w_pre_len  = PW'(DR_PRE);
                w_pre_tms  = DR_PRE_TMS;
                w_n        = PW'(n_q);
                w_post_len = pause_q ? PW'(POST_PAUSE) : PW'(POST_EARLY);
                w_post_tms = pause_q ? POST_PAUSE_TMS : POST_EARLY_TMS;
            end
            default: ;
        endcase
    end

    assign w_shift_end = w_pre_len + w_n;
    assign w_total     = w_shift_end + w_post_len;
    assign w_last      = (pos_q == w_total - PW'(1));
    assign w_phase     = (pos_q < w_pre_len)   ? PH_PREAMBLE :
                         (pos_q < w_shift_end) ? PH_SHIFT    : PH_POSTAMBLE;
    assign w_post_pos  = 3'(pos_q - w_shift_end);
    assign w_idx       = IW'(pos_q - w_pre_len);

    always_comb begin
        case (w_phase)
            PH_PREAMBLE: w_tms_next = w_pre_tms[pos_q[2:0]];
            PH_SHIFT:    w_tms_next = (pos_q == w_shift_end - PW'(1));
            default:     w_tms_next = w_post_tms[w_post_pos];
        endcase
    end

    assign w_tdi_next = (w_phase == PH_SHIFT) & data_q[w_idx];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pause_d     = pause_q;
        n_d         = n_q;
        data_d      = data_q;
        pos_d       = pos_q;
        upd_d       = 1'b0;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        rsp_valid_d = 1'b0;
        if (upd_q) begin
            tms_d = w_tms_next;
            tdi_d = w_tdi_next;
        end
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_SEQ;
                    op_d    = (cmd_op == OP_RSVD) ? OP_RST : cmd_op;
                    pause_d = cmd_pause;
                    data_d  = cmd_data;
                    pos_d   = '0;
                    upd_d   = 1'b1;
                    if (cmd_bits == '0)
                        n_d = BW'(1);
                    else if (cmd_bits > BW'(MAX_DR_BITS))
                        n_d = BW'(MAX_DR_BITS);
                    else
                        n_d = cmd_bits;
                end
            end
            ST_AUTO_RST, ST_SEQ: begin
                if (w_fall) begin
                    if (w_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        pos_d = pos_q + PW'(1);
                        upd_d = 1'b1;
                    end
                end else if (w_rise && w_last && state_q == ST_SEQ) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                if (w_fall) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge trst_) begin
        if (trst_) begin
            state_q     <= ST_AUTO_RST;
            op_q        <= OP_RST;
            pause_q     <= 1'b0;
            n_q         <= BW'(1);
            data_q      <= '0;
            pos_q       <= '0;
            upd_q       <= 1'b1;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pause_q     <= pause_d;
            n_q         <= n_d;
            data_q      <= data_d;
            pos_q       <= pos_d;
            upd_q       <= upd_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
    logic [MAX_DR_BITS-1:0] cap_q;
    logic [MAX_DR_BITS-1:0] rsp_q;

    always_ff @(posedge clk or posedge trst_) begin
        if (trst_) begin
            cap_q <= '0;
            rsp_q <= '0;
        end else begin
            if (state_q == ST_IDLE && cmd_valid)
                cap_q <= '0;
            else if (state_q == ST_SEQ && w_rise && w_phase == PH_SHIFT)
                cap_q[w_idx] <= tdo;
            if (state_q == ST_DONE && w_fall)
                rsp_q <= cap_q;
        end
    end

    assign rsp_data = rsp_q;
`else
    logic w_unused_tdo;

    assign w_unused_tdo = tdo;
    assign rsp_data     = '0;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// =============================================================================
// Module   : tb_jtag_master
// Brief    : Scoreboard bench for jtag_master: expected TMS/TDI streams, TCK
//            counts, latency and captured TDO are queued at issue time and
//            checked by a monitor on each rsp_valid.
// Revision : 1.0 - initial release
// =============================================================================
module tb_jtag_master;

    localparam int D = 5;

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        trst_     = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op    = 2'd0;
    logic [6:0]  cmd_bits  = 7'd0;
    logic        cmd_pause = 1'b0;
    logic [63:0] cmd_data  = 64'd0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        busy, tck, tms, tdi, tdo;

    jtag_master #(
        .IR_LENGTH   (4),
        .MAX_DR_BITS (64),
        .TCK_DIV     (D)
    ) dut (
        .clk       (clk),
        .trst_     (trst_),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_bits  (cmd_bits),
        .cmd_pause (cmd_pause),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           k;
        logic [127:0] tms;
        logic [127:0] tdi;
        logic [63:0]  rsp;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           k = 0;
    logic [127:0] cur_tms = '0;
    logic [127:0] cur_tdi = '0;
    logic         tck_m = 1'b0;
    logic         tms_hi = 1'b0;
    logic         tdi_hi = 1'b0;

    // TDO target: bit p of pat is presented during TCK p of the current command
    logic [127:0] pat = 128'h3C5A_96E1_0F87_D2B4_A5C3_1E69_F078_4B2D;
    int           fc = 0;
    logic         tck_d1 = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        tck_d1 <= tck;
        if (cmd_valid && cmd_ready)
            fc <= 0;
        else if (tck_d1 && !tck)
            fc <= fc + 1;
    end

    assign tdo = pat[fc[6:0]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (trst_) begin
                k       = 0;
                cur_tms = '0;
                cur_tdi = '0;
                tck_m   = 1'b0;
            end else begin
                if (tck && !tck_m) begin
                    if (k < 128) begin
                        cur_tms[k] = tms;
                        cur_tdi[k] = tdi;
                    end
                    tms_hi = tms;
                    tdi_hi = tdi;
                    k++;
                end else if (tck) begin
                    chk("tms_hold_high", tms, tms_hi);
                    chk("tdi_hold_high", tdi, tdi_hi);
                end
                tck_m = tck;
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp_valid", rsp_valid, 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk("tck_count", k, e.k);
                        chk("tms_stream", cur_tms, e.tms);
                        chk("tdi_stream", cur_tdi, e.tdi);
                        chk("rsp_data", rsp_data, e.rsp);
                        chk("latency", cyc - acc_cyc, 1 + 2 * D * e.k);
                        chk("tck_low_at_done", tck, 1'b0);
                        chk("ready_at_done", cmd_ready, 1'b1);
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc + 1;
                    k       = 0;
                    cur_tms = '0;
                    cur_tdi = '0;
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!cmd_ready && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, cmd_ready, 1'b1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] bits, input logic pause,
                         input logic [63:0] data, input int kk, input logic [127:0] etms,
                         input logic [127:0] etdi, input int pre, input int n, input bit push);
        exp_t         e;
        logic [127:0] mask;
        wait_ready("ready_before_issue");
        cmd_op    = op;
        cmd_bits  = bits;
        cmd_pause = pause;
        cmd_data  = data;
        cmd_valid = 1'b1;
        if (push) begin
            mask  = (n == 0) ? '0 : ((128'd1 << n) - 128'd1);
            e.k   = kk;
            e.tms = etms;
            e.tdi = etdi;
            e.rsp = CAP ? 64'((pat >> pre) & mask) : 64'd0;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_bits  = 7'($urandom);
        cmd_pause = 1'($urandom);
        cmd_data  = {$urandom, $urandom};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #2 trst_ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tck", tck, 1'b0);
        chk("rst_tms", tms, 1'b1);
        chk("rst_tdi", tdi, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 64'd0);

        @(negedge clk);
        trst_ = 1'b0;
        @(posedge clk);
        #1;
        wait_ready("auto_rst_ready");
        chk("auto_rst_tcks", k, 6);
        chk("auto_rst_tms", cur_tms, 128'h1F);
        chk("idle_tck", tck, 1'b0);
        chk("idle_tms", tms, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // 32-bit DR, direct exit: 1,0,0, 31x0, 1, 1, 0
        issue(2'd2, 7'd32, 1'b0, 64'd0, 37,
              128'd1 | (128'd1 << 34) | (128'd1 << 35), 128'd0, 3, 32, 1'b1);
        // IR 4'hA, cmd_bits ignored
        issue(2'd1, 7'd50, 1'b0, 64'hA, 10, 128'h183, 128'hA0, 4, 4, 1'b1);
        // 4-bit DR via Pause-DR, upper data bits must not be shifted
        issue(2'd2, 7'd4, 1'b1, 64'hF0F0_0000_0000_000B, 11, 128'h341, 128'h58, 3, 4, 1'b1);
        // cmd_bits 0 clamps to one shift bit
        issue(2'd2, 7'd0, 1'b0, 64'h1, 6, 128'h19, 128'h8, 3, 1, 1'b1);
        // cmd_bits 100 clamps to 64
        issue(2'd2, 7'd100, 1'b0, 64'hDEAD_BEEF_0123_4567, 69,
              128'd1 | (128'd1 << 66) | (128'd1 << 67),
              128'(64'hDEAD_BEEF_0123_4567) << 3, 3, 64, 1'b1);
        issue(2'd0, 7'd9, 1'b1, 64'hFFFF, 6, 128'h1F, 128'd0, 6, 0, 1'b1);
        issue(2'd3, 7'd9, 1'b0, 64'hFFFF, 6, 128'h1F, 128'd0, 6, 0, 1'b1);
        issue(2'd2, 7'd8, 1'b0, 64'hC5, 13, 128'hC01, 128'h628, 3, 8, 1'b1);

        t = 0;
        while (q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("scoreboard_drained", q.size(), 0);

        // Reset in the middle of a 32-bit DR shift (shift bit 10 = TCK 13)
        issue(2'd2, 7'd32, 1'b0, 64'hFFFF_FFFF, 37, 128'd0, 128'd0, 3, 32, 1'b0);
        t = 0;
        while (k < 14 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("reached_shift_bit10", k, 14);
        trst_ = 1'b1;
        #1;
        chk("mid_rst_tck", tck, 1'b0);
        chk("mid_rst_tms", tms, 1'b1);
        chk("mid_rst_ready", cmd_ready, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        trst_ = 1'b0;
        @(posedge clk);
        #1;
        wait_ready("rerun_auto_rst_ready");
        chk("rerun_auto_rst_tcks", k, 6);
        chk("rerun_auto_rst_tms", cur_tms, 128'h1F);
        repeat (5) @(posedge clk);
        chk("no_rsp_after_abort", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
